axi4_lite_write_manager: RTL and testbench

//   AXI4-Lite subordinate write path (AW, W, B channels) for the register block.

---
 rtl/axi4_lite_write_manager.sv | 112 +++++++++++
 tb/tb_axi4_lite_write_manager.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_write_manager.sv
// AXI4-Lite write subordinate: buffers one AW and one W beat, pulses register_write_o, then returns B.
// Latency: last AW/W handshake at E -> write strobe E+1 -> BVALID E+2; AW/W stall until the B handshake.
module axi4_lite_write_manager #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int REGISTERS    = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_clk_ni,
  input  logic [ADDRESS_SIZE-1:0]   write_address_i,
  input  logic                      write_address_valid_i,
  output logic                      write_address_ready_o,
  input  logic [DATA_SIZE-1:0]      write_data_i,
  input  logic [DATA_SIZE/8-1:0]    write_strobe_i,
  input  logic                      write_data_valid_i,
  output logic                      write_data_ready_o,
  output logic [1:0]                write_response_o,
  output logic                      write_response_valid_o,
  input  logic                      write_response_ready_i,
  output logic [ADDRESS_SIZE-1:0]   register_address_o,
  output logic [DATA_SIZE-1:0]      register_data_o,
  output logic [DATA_SIZE/8-1:0]    register_strobe_o,
  output logic                      register_write_o
);

  localparam int STRB_W = DATA_SIZE / 8;
  localparam int OFFSET = $clog2(STRB_W);
  localparam logic [ADDRESS_SIZE-1:0] REG_LIMIT = ADDRESS_SIZE'(REGISTERS);

  typedef enum logic [1:0] {COLLECT, WRITE, RESP} state_t;

  state_t                    state_q, state_d;
  logic                      aw_full_q, aw_full_d;
  logic                      w_full_q, w_full_d;
  logic [ADDRESS_SIZE-1:0]   aw_addr_q;
  logic [DATA_SIZE-1:0]      w_data_q;
  logic [STRB_W-1:0]         w_strb_q;
  logic                      aw_hs, w_hs;
  logic [ADDRESS_SIZE-1:0]   word_index;
  logic                      in_range;
  logic                      issue;
  logic                      b_done;
  logic                      bvalid_d;

  assign aw_hs = write_address_valid_i & write_address_ready_o;
  assign w_hs  = write_data_valid_i & write_data_ready_o;

  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) state_q <= COLLECT;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (aw_full_q && w_full_q) state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (write_response_ready_i) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Buffers only ever fill in COLLECT: the READYs are low everywhere else.
  always_comb begin
    word_index = aw_addr_q >> OFFSET;
    in_range   = (word_index < REG_LIMIT);
    issue      = (state_q == COLLECT) && aw_full_q && w_full_q;
    b_done     = (state_q == RESP) && write_response_ready_i;
    aw_full_d  = b_done ? 1'b0 : (aw_full_q | aw_hs);
    w_full_d   = b_done ? 1'b0 : (w_full_q | w_hs);
    bvalid_d   = write_response_valid_o;
    if (state_q == WRITE) bvalid_d = 1'b1;
    else if (b_done)      bvalid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      aw_full_q              <= 1'b0;
      w_full_q               <= 1'b0;
      aw_addr_q              <= '0;
      w_data_q               <= '0;
      w_strb_q               <= '0;
      write_address_ready_o  <= 1'b0;
      write_data_ready_o     <= 1'b0;
      write_response_o       <= 2'b00;
      write_response_valid_o <= 1'b0;
      register_address_o     <= '0;
      register_data_o        <= '0;
      register_strobe_o      <= '0;
      register_write_o       <= 1'b0;
    end else begin
      aw_full_q              <= aw_full_d;
      w_full_q               <= w_full_d;
      write_address_ready_o  <= !aw_full_d;
      write_data_ready_o     <= !w_full_d;
      write_response_valid_o <= bvalid_d;
      register_write_o       <= issue && in_range;
      if (aw_hs) aw_addr_q <= write_address_i;
      if (w_hs) begin
        w_data_q <= write_data_i;
        w_strb_q <= write_strobe_i;
      end
      if (issue) begin
        register_address_o <= word_index;
        register_data_o    <= w_data_q;
        register_strobe_o  <= w_strb_q;
        write_response_o   <= in_range ? 2'b00 : 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_write_manager.sv
// Directed bench for axi4_lite_write_manager with REGISTERS=4.
module tb_axi4_lite_write_manager;

  logic        clk_i = 1'b0;
  logic        rst_clk_ni = 1'b0;
  logic [31:0] write_address_i = '0;
  logic        write_address_valid_i = 1'b0;
  logic        write_address_ready_o;
  logic [31:0] write_data_i = '0;
  logic [3:0]  write_strobe_i = '0;
  logic        write_data_valid_i = 1'b0;
  logic        write_data_ready_o;
  logic [1:0]  write_response_o;
  logic        write_response_valid_o;
  logic        write_response_ready_i = 1'b0;
  logic [31:0] register_address_o;
  logic [31:0] register_data_o;
  logic [3:0]  register_strobe_o;
  logic        register_write_o;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int base;

  axi4_lite_write_manager #(.ADDRESS_SIZE(32), .DATA_SIZE(32), .REGISTERS(4)) dut (
    .clk_i(clk_i), .rst_clk_ni(rst_clk_ni),
    .write_address_i(write_address_i), .write_address_valid_i(write_address_valid_i),
    .write_address_ready_o(write_address_ready_o),
    .write_data_i(write_data_i), .write_strobe_i(write_strobe_i),
    .write_data_valid_i(write_data_valid_i), .write_data_ready_o(write_data_ready_o),
    .write_response_o(write_response_o), .write_response_valid_o(write_response_valid_o),
    .write_response_ready_i(write_response_ready_i),
    .register_address_o(register_address_o), .register_data_o(register_data_o),
    .register_strobe_o(register_strobe_o), .register_write_o(register_write_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (register_write_o) wr_count++;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ready(input string tag, input logic aw, input logic w);
    check({tag, "_awready"}, 64'(write_address_ready_o), 64'(aw));
    check({tag, "_wready"}, 64'(write_data_ready_o), 64'(w));
  endtask

  initial begin
    // 1: reset and release
    tick(); tick();
    check_ready("rst", 1'b0, 1'b0);
    check("rst_bvalid", 64'(write_response_valid_o), 64'd0);
    check("rst_regwr", 64'(register_write_o), 64'd0);
    rst_clk_ni = 1'b1;
    check_ready("rel_pre", 1'b0, 1'b0);
    tick();
    check_ready("rel_post", 1'b1, 1'b1);
    check("rel_bvalid", 64'(write_response_valid_o), 64'd0);

    // 2: AW and W on the same edge
    write_address_i = 32'h8; write_address_valid_i = 1'b1;
    write_data_i = 32'hDEADBEEF; write_strobe_i = 4'hF; write_data_valid_i = 1'b1;
    tick();
    write_address_valid_i = 1'b0; write_data_valid_i = 1'b0;
    check_ready("t2_E", 1'b0, 1'b0);
    check("t2_E_regwr", 64'(register_write_o), 64'd0);
    tick();
    check("t2_regwr", 64'(register_write_o), 64'd1);
    check("t2_addr", 64'(register_address_o), 64'd2);
    check("t2_data", 64'(register_data_o), 64'hDEADBEEF);
    check("t2_strb", 64'(register_strobe_o), 64'hF);
    check("t2_bvalid_early", 64'(write_response_valid_o), 64'd0);
    tick();
    check("t2_regwr_off", 64'(register_write_o), 64'd0);
    check("t2_bvalid", 64'(write_response_valid_o), 64'd1);
    check("t2_bresp", 64'(write_response_o), 64'd0);
    write_response_ready_i = 1'b1;
    tick();
    write_response_ready_i = 1'b0;
    check("t2_bvalid_done", 64'(write_response_valid_o), 64'd0);
    check_ready("t2_done", 1'b1, 1'b1);
    check("t2_count", 64'(wr_count), 64'd1);

    // 3: W first, AW five cycles later
    write_data_i = 32'h12345678; write_strobe_i = 4'h3; write_data_valid_i = 1'b1;
    tick();
    write_data_valid_i = 1'b0;
    check_ready("t3_w", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_wready_hold", 64'(write_data_ready_o), 64'd0);
      check("t3_no_write", 64'(register_write_o), 64'd0);
    end
    write_address_i = 32'h4; write_address_valid_i = 1'b1;
    tick();
    write_address_valid_i = 1'b0;
    check_ready("t3_aw", 1'b0, 1'b0);
    tick();
    check("t3_regwr", 64'(register_write_o), 64'd1);
    check("t3_addr", 64'(register_address_o), 64'd1);
    check("t3_data", 64'(register_data_o), 64'h12345678);
    check("t3_strb", 64'(register_strobe_o), 64'h3);
    tick();
    check("t3_bvalid", 64'(write_response_valid_o), 64'd1);
    check("t3_bresp", 64'(write_response_o), 64'd0);
    write_response_ready_i = 1'b1;
    tick();
    write_response_ready_i = 1'b0;
    check("t3_bvalid_done", 64'(write_response_valid_o), 64'd0);
    check("t3_count", 64'(wr_count), 64'd2);

    // 4: out-of-range index -> SLVERR, no write
    write_address_i = 32'h40; write_address_valid_i = 1'b1;
    write_data_i = 32'hCAFEF00D; write_strobe_i = 4'hF; write_data_valid_i = 1'b1;
    tick();
    write_address_valid_i = 1'b0; write_data_valid_i = 1'b0;
    tick();
    check("t4_regwr", 64'(register_write_o), 64'd0);
    tick();
    check("t4_bvalid", 64'(write_response_valid_o), 64'd1);
    check("t4_bresp", 64'(write_response_o), 64'h2);
    check("t4_count", 64'(wr_count), 64'd2);

    // 5: BREADY low for 10 cycles while a new write is offered
    write_address_i = 32'h0; write_address_valid_i = 1'b1;
    write_data_i = 32'hA5A5A5A5; write_strobe_i = 4'hF; write_data_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_bvalid_hold", 64'(write_response_valid_o), 64'd1);
      check("t5_bresp_hold", 64'(write_response_o), 64'h2);
      check_ready("t5_stall", 1'b0, 1'b0);
    end
    write_response_ready_i = 1'b1;
    tick();
    write_response_ready_i = 1'b0;
    check("t5_bvalid_done", 64'(write_response_valid_o), 64'd0);
    check_ready("t5_reopen", 1'b1, 1'b1);
    tick();
    write_address_valid_i = 1'b0; write_data_valid_i = 1'b0;
    check_ready("t5_accept", 1'b0, 1'b0);
    tick();
    check("t5_regwr", 64'(register_write_o), 64'd1);
    check("t5_addr", 64'(register_address_o), 64'd0);
    check("t5_data", 64'(register_data_o), 64'hA5A5A5A5);
    tick();
    check("t5_bvalid", 64'(write_response_valid_o), 64'd1);
    check("t5_bresp", 64'(write_response_o), 64'd0);

    // 6: asynchronous reset while in RESP
    base = wr_count;
    #2 rst_clk_ni = 1'b0;
    #1;
    check("t6_bvalid_async", 64'(write_response_valid_o), 64'd0);
    tick(); tick();
    check_ready("t6_in_rst", 1'b0, 1'b0);
    check("t6_no_write", 64'(wr_count), 64'(base));
    rst_clk_ni = 1'b1;
    tick();
    check_ready("t6_rel", 1'b1, 1'b1);
    check("t6_bvalid_rel", 64'(write_response_valid_o), 64'd0);

    // zero strobe, last in-range index
    write_address_i = 32'hC; write_address_valid_i = 1'b1;
    write_data_i = 32'h0; write_strobe_i = 4'h0; write_data_valid_i = 1'b1;
    tick();
    write_address_valid_i = 1'b0; write_data_valid_i = 1'b0;
    tick();
    check("t7_regwr", 64'(register_write_o), 64'd1);
    check("t7_addr", 64'(register_address_o), 64'd3);
    check("t7_strb", 64'(register_strobe_o), 64'd0);
    tick();
    check("t7_bvalid", 64'(write_response_valid_o), 64'd1);
    check("t7_bresp", 64'(write_response_o), 64'd0);
    write_response_ready_i = 1'b1;
    tick();
    write_response_ready_i = 1'b0;
    check("t7_bvalid_done", 64'(write_response_valid_o), 64'd0);
    check("t7_count", 64'(wr_count), 64'(base + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
